psum_acc_fifo: RTL and testbench
================================

PSUM_ACC_FIFO -- requirements
Module: psum_acc_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one signed lane value.
REQ-002 SHALL have parameter LANES, default 4, number of parallel partial-sum lanes per entry.
REQ-003 SHALL have parameter ADD_WIDTH, default 4, pointer width; depth = 2**ADD_WIDTH entries.
REQ-004 SHALL have parameter SAT_EN, default 1, 1 = saturating accumulate, 0 = wrap-around accumulate.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port clr  input  1  synchronous clear of pointers, count and sticky flags.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port acc_en  input  1  when 1, written value = data_in_fifo + psum_buffer per lane.
REQ-010 SHALL have port data_in_fifo  input  LANES*DATA_WIDTH  signed lane data; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port psum_buffer  input  LANES*DATA_WIDTH  signed partial sums, same packing.
REQ-012 SHALL have port rd_en  input  1  read request.
REQ-013 SHALL have port data_out_fifo  output  LANES*DATA_WIDTH  registered read data.
REQ-014 SHALL have port rd_valid  output  1  data_out_fifo valid this cycle.
REQ-015 SHALL have port full / empty  output  1 each  occupancy flags.
REQ-016 SHALL have port count  output  ADD_WIDTH+1  entries stored.
REQ-017 SHALL have port ovf_err / udf_err  output  1 each  one-cycle pulses: rejected write / rejected read.
REQ-018 SHALL have port sat_flag  output  1  sticky: some lane saturated since last reset/clr.

Function
REQ-019 Write SHALL be accepted iff wr_en=1, clr=0 and full=0; accepted entry stored at wr_ptr, wr_ptr increments modulo depth.
REQ-020 Read SHALL be accepted iff rd_en=1, clr=0 and empty=0; entry at rd_ptr registered to data_out_fifo, rd_ptr increments modulo depth.
REQ-021 Read latency SHALL be 1 cycle: rd_valid=1 the cycle after an accepted read, else 0.
REQ-022 data_out_fifo SHALL be 0 in every cycle rd_valid=0.
REQ-023 full/empty SHALL be evaluated from registered count before the edge; simultaneous wr_en+rd_en when full: read accepted, write rejected; when empty: write accepted, read rejected.
REQ-024 count SHALL +1 on write only, -1 on read only, unchanged on both or neither; full = (count == depth), empty = (count == 0).
REQ-025 Accumulate SHALL be a per-lane signed add at DATA_WIDTH+1 bits; no carry between lanes.
REQ-026 With SAT_EN=1 result SHALL clamp to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1] and set sat_flag on any clamped lane of an accepted write.
REQ-027 With SAT_EN=0 result SHALL wrap modulo 2**DATA_WIDTH; sat_flag stays 0.
REQ-028 acc_en=0 SHALL store data_in_fifo unchanged; psum_buffer ignored.
REQ-029 ovf_err SHALL pulse the cycle after wr_en=1 rejected because full; udf_err likewise for rd_en=1 rejected because empty; no pulse while clr=1.
REQ-030 clr=1 SHALL, at the edge, zero pointers, count, sat_flag, rd_valid, data_out_fifo; overrides wr_en/rd_en; memory contents not cleared.

Reset
REQ-031 rst_n=0 SHALL immediately zero wr_ptr, rd_ptr, count, data_out_fifo, rd_valid, full, ovf_err, udf_err, sat_flag and set empty=1.
REQ-032 Reset mid-operation SHALL discard all stored entries; memory array needs no reset.
REQ-033 Release of rst_n SHALL take effect at the next clk edge; first write accepted on that edge.

Verification
REQ-034 Reset, write 16 entries (ADD_WIDTH=4) lane values 1..16 acc_en=0 -> full=1 count=16; 17th write -> ovf_err one-cycle pulse, count stays 16.
REQ-035 Read all 16 -> data_out_fifo 1..16 in order, each one cycle after rd_en with rd_valid=1; 17th read -> udf_err pulse, empty=1, rd_valid=0, data_out_fifo=0.
REQ-036 SAT_EN=1, acc_en=1, lane0 0x7FF0+0x0020 and lane1 0x8000+0xFFFF -> stored 0x7FFF and 0x8000, sat_flag=1 until clr; lane2 5+(-3) -> 2.
REQ-037 Full FIFO, wr_en=rd_en=1 same cycle -> read accepted, write rejected, ovf_err=1, count 15; empty FIFO, both -> write only, udf_err=1, count 1.
REQ-038 Write 10, read 10, write 10 -> pointers wrap past 15, data order preserved; then clr=1 with wr_en=1 -> count=0, empty=1, no write stored.
REQ-039 rst_n=0 asserted asynchronously between edges with count=5 -> outputs at reset values before next edge; post-release reads give udf_err.

Source files
------------

// File: rtl/psum_acc_fifo.sv
// Partial-sum FIFO: each written entry is either the raw lane data or a per-lane
// signed sum of lane data and an incoming partial sum (optionally saturating).
module psum_acc_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int ADD_WIDTH  = 4,
    parameter int SAT_EN     = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          wr_en,
    input  logic                          acc_en,
    input  logic [LANES*DATA_WIDTH-1:0]   data_in_fifo,
    input  logic [LANES*DATA_WIDTH-1:0]   psum_buffer,
    input  logic                          rd_en,
    output logic [LANES*DATA_WIDTH-1:0]   data_out_fifo,
    output logic                          rd_valid,
    output logic                          full,
    output logic                          empty,
    output logic [ADD_WIDTH:0]            count,
    output logic                          ovf_err,
    output logic                          udf_err,
    output logic                          sat_flag
);

    localparam int                 DEPTH   = 2 ** ADD_WIDTH;
    localparam int                 W       = LANES * DATA_WIDTH;
    localparam logic [ADD_WIDTH:0] DEPTH_C = (ADD_WIDTH + 1)'(DEPTH);

    // Returns {clamped, result} for one lane; sum is formed one bit wider so overflow is visible.
    function automatic logic [DATA_WIDTH:0] lane_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0]   sum;
        logic [DATA_WIDTH-1:0] res;
        logic                  clamped;
        sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if ((SAT_EN != 0) && (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])) begin
            clamped = 1'b1;
            if (sum[DATA_WIDTH]) begin
                res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end else begin
            clamped = 1'b0;
            res     = sum[DATA_WIDTH-1:0];
        end
        return {clamped, res};
    endfunction

    // Whole-entry accumulate: {any lane clamped, packed lane results}.
    function automatic logic [W:0] acc_vec(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0]        res;
        logic                hit;
        logic [DATA_WIDTH:0] r;
        res = '0;
        hit = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            r = lane_add(a[l*DATA_WIDTH +: DATA_WIDTH], b[l*DATA_WIDTH +: DATA_WIDTH]);
            res[l*DATA_WIDTH +: DATA_WIDTH] = r[DATA_WIDTH-1:0];
            hit = hit | r[DATA_WIDTH];
        end
        return {hit, res};
    endfunction

    logic [W-1:0]           mem_q [DEPTH];
    logic [ADD_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADD_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADD_WIDTH:0]     count_q, count_d;
    logic [W-1:0]           dout_q, dout_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;
    logic                   sat_q, sat_d;

    logic                   full_s, empty_s;
    logic                   wr_acc_s, rd_acc_s;
    logic [W:0]             acc_res_s;
    logic [W-1:0]           wr_data_s;
    logic                   sat_hit_s;

    assign full_s    = (count_q == DEPTH_C);
    assign empty_s   = (count_q == '0);
    assign wr_acc_s  = wr_en & ~clr & ~full_s;
    assign rd_acc_s  = rd_en & ~clr & ~empty_s;
    assign acc_res_s = acc_vec(data_in_fifo, psum_buffer);

    // Select the value stored on a write: accumulated or raw lane data.
    always_comb begin
        wr_data_s = data_in_fifo;
        sat_hit_s = 1'b0;
        if (acc_en) begin
            wr_data_s = acc_res_s[W-1:0];
            sat_hit_s = acc_res_s[W];
        end else begin
            wr_data_s = data_in_fifo;
            sat_hit_s = 1'b0;
        end
    end

    // Next-state for pointers, occupancy, read data and status pulses.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        dout_d     = '0;
        rd_valid_d = 1'b0;
        ovf_d      = 1'b0;
        udf_d      = 1'b0;
        sat_d      = sat_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            sat_d    = 1'b0;
        end else begin
            ovf_d = wr_en & full_s;
            udf_d = rd_en & empty_s;
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + ADD_WIDTH'(1);
                sat_d    = sat_q | sat_hit_s;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d   = rd_ptr_q + ADD_WIDTH'(1);
                dout_d     = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + (ADD_WIDTH + 1)'(1);
                2'b01:   count_d = count_q - (ADD_WIDTH + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and status state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            sat_q      <= sat_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

    assign data_out_fifo = dout_q;
    assign rd_valid      = rd_valid_q;
    assign full          = full_s;
    assign empty         = empty_s;
    assign count         = count_q;
    assign ovf_err       = ovf_q;
    assign udf_err       = udf_q;
    assign sat_flag      = sat_q;

endmodule

// File: tb/tb_psum_acc_fifo.sv
// Directed bench for psum_acc_fifo with default parameters (16-bit lanes, 4 lanes, depth 16).
module tb_psum_acc_fifo;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int W  = DW * LN;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic          acc_en;
    logic [W-1:0]  data_in_fifo;
    logic [W-1:0]  psum_buffer;
    logic          rd_en;
    logic [W-1:0]  data_out_fifo;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [4:0]    count;
    logic          ovf_err;
    logic          udf_err;
    logic          sat_flag;

    int n_checks;
    int n_errors;

    psum_acc_fifo #(.DATA_WIDTH(DW), .LANES(LN), .ADD_WIDTH(4), .SAT_EN(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (clr),
        .wr_en         (wr_en),
        .acc_en        (acc_en),
        .data_in_fifo  (data_in_fifo),
        .psum_buffer   (psum_buffer),
        .rd_en         (rd_en),
        .data_out_fifo (data_out_fifo),
        .rd_valid      (rd_valid),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .ovf_err       (ovf_err),
        .udf_err       (udf_err),
        .sat_flag      (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entry k: lane i holds k + 256*i so lane order is observable.
    function automatic logic [W-1:0] mkword(input int k);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < LN; i++) w[i*DW +: DW] = 16'(k + i * 256);
        return w;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; acc_en = 1'b0; rd_en = 1'b0;
        data_in_fifo = '0; psum_buffer = '0;
        #3;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_rdv", 64'(rd_valid), 64'd0);
        chk("rst_dout", 64'(data_out_fifo), 64'd0);
        chk("rst_flags", 64'({ovf_err, udf_err, sat_flag}), 64'd0);
        #9 rst_n = 1'b1;

        // Fill to full, then one rejected write.
        wr_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            data_in_fifo = mkword(k);
            psum_buffer  = {4{16'h1111}};
            step();
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_ovf0", 64'(ovf_err), 64'd0);
        data_in_fifo = mkword(77);
        step();
        chk("ovf_pulse", 64'(ovf_err), 64'd1);
        chk("ovf_count", 64'(count), 64'd16);
        wr_en = 1'b0;
        step();
        chk("ovf_drop", 64'(ovf_err), 64'd0);

        // Drain in order, then one rejected read.
        rd_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("drain_rdv", 64'(rd_valid), 64'd1);
            chk("drain_data", 64'(data_out_fifo), 64'(mkword(k)));
        end
        step();
        chk("udf_pulse", 64'(udf_err), 64'd1);
        chk("udf_empty", 64'(empty), 64'd1);
        chk("udf_rdv", 64'(rd_valid), 64'd0);
        chk("udf_dout", 64'(data_out_fifo), 64'd0);
        rd_en = 1'b0;
        step();
        chk("udf_drop", 64'(udf_err), 64'd0);

        // Accumulate: non-clamping extremes, clamping case, then raw write.
        wr_en = 1'b1; acc_en = 1'b1;
        data_in_fifo = {16'd7, 16'd100, 16'h8000, 16'h7FFF};
        psum_buffer  = {16'd1, 16'hFED4, 16'h7FFF, 16'h8000};
        step();
        chk("acc_nosat", 64'(sat_flag), 64'd0);
        data_in_fifo = {16'd1, 16'd5, 16'h8000, 16'h7FF0};
        psum_buffer  = {16'd2, 16'hFFFD, 16'hFFFF, 16'h0020};
        step();
        chk("acc_sat", 64'(sat_flag), 64'd1);
        acc_en = 1'b0;
        data_in_fifo = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        psum_buffer  = {4{16'hFFFF}};
        step();
        chk("sat_sticky", 64'(sat_flag), 64'd1);
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        chk("acc_wrap_free", 64'(data_out_fifo), 64'h0008_FF38_FFFF_FFFF);
        step();
        chk("acc_clamp", 64'(data_out_fifo), 64'h0003_0002_8000_7FFF);
        step();
        chk("acc_raw", 64'(data_out_fifo), 64'h1111_2222_3333_4444);
        rd_en = 1'b0; clr = 1'b1;
        step();
        chk("clr_sat", 64'(sat_flag), 64'd0);
        clr = 1'b0;

        // Simultaneous read/write when full.
        wr_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            data_in_fifo = mkword(32 + k);
            step();
        end
        rd_en = 1'b1;
        data_in_fifo = mkword(90);
        step();
        chk("both_full_ovf", 64'(ovf_err), 64'd1);
        chk("both_full_cnt", 64'(count), 64'd15);
        chk("both_full_data", 64'(data_out_fifo), 64'(mkword(33)));
        wr_en = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            step();
            chk("both_full_rest", 64'(data_out_fifo), 64'(mkword(32 + k)));
        end
        rd_en = 1'b0;
        step();
        chk("both_full_empty", 64'(empty), 64'd1);

        // Simultaneous read/write when empty.
        wr_en = 1'b1; rd_en = 1'b1;
        data_in_fifo = mkword(99);
        step();
        chk("both_empty_udf", 64'(udf_err), 64'd1);
        chk("both_empty_cnt", 64'(count), 64'd1);
        chk("both_empty_rdv", 64'(rd_valid), 64'd0);
        wr_en = 1'b0;
        step();
        chk("both_empty_data", 64'(data_out_fifo), 64'(mkword(99)));
        rd_en = 1'b0;

        // Pointer wrap with order preserved.
        for (int r = 0; r < 2; r++) begin
            wr_en = 1'b1;
            for (int k = 0; k < 10; k++) begin
                data_in_fifo = mkword(200 + 100 * r + k);
                step();
            end
            wr_en = 1'b0; rd_en = 1'b1;
            for (int k = 0; k < 10; k++) begin
                step();
                chk("wrap_data", 64'(data_out_fifo), 64'(mkword(200 + 100 * r + k)));
            end
            rd_en = 1'b0;
        end

        // Clear overrides a concurrent write.
        wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in_fifo = mkword(500 + k);
            step();
        end
        clr = 1'b1;
        step();
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_empty", 64'(empty), 64'd1);
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
        step();
        chk("clr_nowrite", 64'(udf_err), 64'd1);
        rd_en = 1'b0;

        // Asynchronous reset between edges with entries stored.
        wr_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data_in_fifo = mkword(400 + k);
            step();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("pre_rst_cnt", 64'(count), 64'd5);
        chk("pre_rst_rdv", 64'(rd_valid), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_rdv", 64'(rd_valid), 64'd0);
        chk("arst_dout", 64'(data_out_fifo), 64'd0);
        rst_n = 1'b1;
        rd_en = 1'b1;
        step();
        chk("post_rst_udf", 64'(udf_err), 64'd1);
        chk("post_rst_rdv", 64'(rd_valid), 64'd0);
        rd_en = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
